// File: rtl/sprite_pkg.sv
// Shared sprite-engine constants and types: line geometry, pixel format, colour key.
package sprite_pkg;

  localparam int unsigned PIX_W  = 16;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned LINE_W = 640;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [COL_W-1:0] col_t;

  localparam pixel_t TRANSPARENT = 16'h0000;
  localparam col_t   LINE_END    = col_t'(LINE_W);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } lb_state_e;

  typedef enum logic [1:0] {
    RD_TRANSP,
    RD_BANK0,
    RD_BANK1
  } rd_src_e;

  function automatic logic col_in_line(input col_t c);
    return c < LINE_END;
  endfunction

endpackage

// File: rtl/sprite_line_bank.sv
// One scanline bank: single write port, registered read port returning old data on collision.
module sprite_line_bank
  import sprite_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [COL_W-1:0] waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             re,
  input  logic [COL_W-1:0] raddr,
  output logic [PIX_W-1:0] rdata
);

  pixel_t mem_q [LINE_W];
  pixel_t rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sprite_line_buffer.sv
// Ping-pong scanline buffer between the sprite engine (draw side) and VGA scanout
// (display side); display entries are cleared as they are read.
module sprite_line_buffer
  import sprite_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             line_swap,
  input  logic [COL_W-1:0] sprite_pixel_col,
  input  logic [PIX_W-1:0] sprite_pixel_data,
  input  logic             wren_pixel_draw,
  input  logic             draw_done,
  input  logic             rd_en,
  input  logic [COL_W-1:0] rd_col,
  output logic [PIX_W-1:0] rd_pixel,
  output logic             rd_valid,
  output logic             rd_opaque,
  output logic             ready,
  output logic [7:0]       late_count
);

  lb_state_e  state_q, state_d;
  col_t       ptr_q, ptr_d;
  logic       disp_bank_q, disp_bank_d;
  logic       done_seen_q, done_seen_d;
  logic [7:0] late_q, late_d;
  logic       rd_valid_q;
  rd_src_e    rd_src_q, rd_src_d;

  logic   draw_ok, rd_hit;
  logic   we    [2];
  col_t   waddr [2];
  pixel_t wdata [2];
  logic   re    [2];
  pixel_t rdata [2];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rd_src_d    = rd_src_q;
    disp_bank_d = line_swap ? ~disp_bank_q : disp_bank_q;
    done_seen_d = line_swap ? 1'b0 : (done_seen_q | draw_done);
    late_d      = late_q;
    draw_ok     = wren_pixel_draw && col_in_line(sprite_pixel_col)
                  && (sprite_pixel_data != TRANSPARENT);
    rd_hit      = rd_en && col_in_line(rd_col);
    for (int unsigned b = 0; b < 2; b++) begin
      we[b]    = 1'b0;
      waddr[b] = ptr_q;
      wdata[b] = TRANSPARENT;
      re[b]    = 1'b0;
    end

    case (state_q)
      ST_CLEAR: begin
        for (int unsigned b = 0; b < 2; b++) we[b] = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LINE_END - 1'b1) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end
        if (rd_en) rd_src_d = RD_TRANSP;
      end
      ST_RUN: begin
        // The display bank's only write is the clear-on-read; the draw bank's is the engine.
        for (int unsigned b = 0; b < 2; b++) begin
          if (b[0] == disp_bank_q) begin
            we[b]    = rd_hit;
            waddr[b] = rd_col;
            re[b]    = rd_hit;
          end else begin
            we[b]    = draw_ok;
            waddr[b] = sprite_pixel_col;
            wdata[b] = sprite_pixel_data;
          end
        end
        if (rd_en) begin
          if (!rd_hit)          rd_src_d = RD_TRANSP;
          else if (disp_bank_q) rd_src_d = RD_BANK1;
          else                  rd_src_d = RD_BANK0;
        end
        if (line_swap && !done_seen_q && !draw_done && (late_q != 8'hFF))
          late_d = late_q + 8'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      disp_bank_q <= 1'b0;
      done_seen_q <= 1'b0;
      late_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_src_q    <= RD_TRANSP;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      disp_bank_q <= disp_bank_d;
      done_seen_q <= done_seen_d;
      late_q      <= late_d;
      rd_valid_q  <= rd_en;
      rd_src_q    <= rd_src_d;
    end
  end

  sprite_line_bank u_bank0 (
    .clk   (clk),
    .we    (we[0]),
    .waddr (waddr[0]),
    .wdata (wdata[0]),
    .re    (re[0]),
    .raddr (rd_col),
    .rdata (rdata[0])
  );

  sprite_line_bank u_bank1 (
    .clk   (clk),
    .we    (we[1]),
    .waddr (waddr[1]),
    .wdata (wdata[1]),
    .re    (re[1]),
    .raddr (rd_col),
    .rdata (rdata[1])
  );

  // The source select is held while rd_en is low, so rd_pixel keeps its last value.
  always_comb begin
    case (rd_src_q)
      RD_BANK0: rd_pixel = rdata[0];
      RD_BANK1: rd_pixel = rdata[1];
      default:  rd_pixel = TRANSPARENT;
    endcase
  end

  assign rd_valid   = rd_valid_q;
  assign rd_opaque  = rd_valid_q && (rd_pixel != TRANSPARENT);
  assign ready      = (state_q == ST_RUN);
  assign late_count = late_q;

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Directed bench for sprite_line_buffer: vector table plus reset/clear/saturation sequences.
module tb_sprite_line_buffer;
  import sprite_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       line_swap;
  logic [9:0] sprite_pixel_col;
  logic [15:0] sprite_pixel_data;
  logic       wren_pixel_draw;
  logic       draw_done;
  logic       rd_en;
  logic [9:0] rd_col;
  logic [15:0] rd_pixel;
  logic       rd_valid;
  logic       rd_opaque;
  logic       ready;
  logic [7:0] late_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_line_buffer dut (
    .clk               (clk),
    .reset             (reset),
    .line_swap         (line_swap),
    .sprite_pixel_col  (sprite_pixel_col),
    .sprite_pixel_data (sprite_pixel_data),
    .wren_pixel_draw   (wren_pixel_draw),
    .draw_done         (draw_done),
    .rd_en             (rd_en),
    .rd_col            (rd_col),
    .rd_pixel          (rd_pixel),
    .rd_valid          (rd_valid),
    .rd_opaque         (rd_opaque),
    .ready             (ready),
    .late_count        (late_count)
  );

  // mode: 0 = no check, 1 = read outputs and late_count, 2 = late_count only
  typedef struct {
    logic        sw;
    logic        wr;
    logic [9:0]  col;
    logic [15:0] dat;
    logic        dd;
    logic        re;
    logic [9:0]  rc;
    int          mode;
    logic [15:0] ep;
    logic        ev;
    logic        eo;
    logic [7:0]  el;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic sw, input logic wr, input int col, input logic [15:0] dat,
                             input logic dd, input logic re, input int rc, input int mode,
                             input logic [15:0] ep, input logic ev, input logic eo,
                             input int el, input string nm);
    vec_t r;
    r.sw = sw; r.wr = wr; r.col = 10'(col); r.dat = dat; r.dd = dd; r.re = re; r.rc = 10'(rc);
    r.mode = mode; r.ep = ep; r.ev = ev; r.eo = eo; r.el = 8'(el); r.nm = nm;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t x);
    line_swap = x.sw; wren_pixel_draw = x.wr; sprite_pixel_col = x.col;
    sprite_pixel_data = x.dat; draw_done = x.dd; rd_en = x.re; rd_col = x.rc;
    step();
    if (x.mode >= 1) chk({x.nm, ".late"}, 32'(late_count), 32'(x.el));
    if (x.mode == 1) begin
      chk({x.nm, ".pixel"}, 32'(rd_pixel), 32'(x.ep));
      chk({x.nm, ".valid"}, 32'(rd_valid), 32'(x.ev));
      chk({x.nm, ".opaque"}, 32'(rd_opaque), 32'(x.eo));
    end
  endtask

  task automatic quiet();
    line_swap = 0; wren_pixel_draw = 0; sprite_pixel_col = '0; sprite_pixel_data = '0;
    draw_done = 0; rd_en = 0; rd_col = '0;
  endtask

  task automatic wait_ready(input string nm, input int already);
    int n;
    n = already;
    while (!ready && n < 2000) begin
      step();
      n++;
    end
    chk({nm, ".clear_cycles"}, 32'(n), 32'd640);
  endtask

  task automatic read_all_zero(input string nm);
    int bad;
    bad = 0;
    for (int c = 0; c < 640; c++) begin
      apply(v(0, 0, 0, 16'h0, 0, 1, c, 0, 16'h0, 0, 0, 0, nm));
      if (rd_pixel !== 16'h0000 || rd_valid !== 1'b1 || rd_opaque !== 1'b0) bad++;
    end
    chk({nm, ".bad_reads"}, 32'(bad), 32'd0);
    quiet();
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, ".rd_pixel"}, 32'(rd_pixel), 32'h0);
    chk({nm, ".rd_valid"}, 32'(rd_valid), 32'h0);
    chk({nm, ".rd_opaque"}, 32'(rd_opaque), 32'h0);
    chk({nm, ".ready"}, 32'(ready), 32'h0);
    chk({nm, ".late"}, 32'(late_count), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    quiet();
    reset = 1;
    step();
    step();
    check_reset_outputs("reset");

    // first clear: read during CLEAR returns transparent, swap during CLEAR is never late
    reset = 0;
    rd_en = 1; rd_col = 10'd3; line_swap = 1;
    step();
    chk("clear_read.valid", 32'(rd_valid), 32'h1);
    chk("clear_read.pixel", 32'(rd_pixel), 32'h0);
    chk("clear_read.ready", 32'(ready), 32'h0);
    line_swap = 0; rd_en = 0;
    wait_ready("init", 1);
    chk("clear_swap.late", 32'(late_count), 32'h0);
    read_all_zero("idle_read");

    tbl.push_back(v(0, 1, 100, 16'hF800, 0, 0, 0,   0, 16'h0,    0, 0, 0, "draw100"));
    tbl.push_back(v(0, 1, 639, 16'h07E0, 0, 0, 0,   0, 16'h0,    0, 0, 0, "draw639"));
    tbl.push_back(v(0, 0, 0,   16'h0,    1, 0, 0,   0, 16'h0,    0, 0, 0, "done1"));
    tbl.push_back(v(1, 0, 0,   16'h0,    0, 0, 0,   2, 16'h0,    0, 0, 0, "swap1"));
    tbl.push_back(v(0, 0, 0,   16'h0,    0, 1, 100, 1, 16'hF800, 1, 1, 0, "rd100"));
    tbl.push_back(v(0, 0, 0,   16'h0,    0, 0, 0,   1, 16'hF800, 0, 0, 0, "hold"));
    tbl.push_back(v(0, 0, 0,   16'h0,    0, 1, 639, 1, 16'h07E0, 1, 1, 0, "rd639"));
    tbl.push_back(v(0, 0, 0,   16'h0,    0, 1, 100, 1, 16'h0,    1, 0, 0, "reread100"));
    tbl.push_back(v(0, 0, 0,   16'h0,    0, 1, 639, 1, 16'h0,    1, 0, 0, "reread639"));
    tbl.push_back(v(0, 1, 640, 16'hFFFF, 0, 0, 0,   0, 16'h0,    0, 0, 0, "draw640"));
    tbl.push_back(v(0, 1, 5,   16'h0000, 0, 0, 0,   0, 16'h0,    0, 0, 0, "draw5_transp"));
    tbl.push_back(v(1, 0, 0,   16'h0,    1, 0, 0,   2, 16'h0,    0, 0, 0, "swap_with_done"));
    tbl.push_back(v(0, 0, 0,   16'h0,    0, 1, 5,   1, 16'h0,    1, 0, 0, "rd5"));
    tbl.push_back(v(0, 0, 0,   16'h0,    0, 1, 640, 1, 16'h0,    1, 0, 0, "rd640"));
    tbl.push_back(v(0, 0, 0,   16'h0,    0, 1, 100, 1, 16'h0,    1, 0, 0, "rd100_empty"));
    tbl.push_back(v(0, 0, 0,   16'h0,    0, 1, 639, 1, 16'h0,    1, 0, 0, "rd639_empty"));
    tbl.push_back(v(0, 1, 50,  16'h001F, 0, 0, 0,   0, 16'h0,    0, 0, 0, "draw50a"));
    tbl.push_back(v(0, 1, 50,  16'h0010, 0, 0, 0,   0, 16'h0,    0, 0, 0, "draw50b"));
    tbl.push_back(v(0, 0, 0,   16'h0,    1, 0, 0,   0, 16'h0,    0, 0, 0, "done2"));
    tbl.push_back(v(1, 0, 0,   16'h0,    0, 0, 0,   2, 16'h0,    0, 0, 0, "swap2"));
    tbl.push_back(v(0, 1, 50,  16'hABCD, 0, 1, 50,  1, 16'h0010, 1, 1, 0, "rd50_last_wins"));
    tbl.push_back(v(0, 0, 0,   16'h0,    1, 0, 0,   0, 16'h0,    0, 0, 0, "done3"));
    tbl.push_back(v(1, 0, 0,   16'h0,    0, 0, 0,   2, 16'h0,    0, 0, 0, "swap3"));
    tbl.push_back(v(0, 0, 0,   16'h0,    0, 1, 50,  1, 16'hABCD, 1, 1, 0, "rd50_same_col"));
    tbl.push_back(v(1, 0, 0,   16'h0,    0, 0, 0,   2, 16'h0,    0, 0, 1, "late1"));
    tbl.push_back(v(1, 0, 0,   16'h0,    0, 0, 0,   2, 16'h0,    0, 0, 2, "late2"));
    tbl.push_back(v(1, 0, 0,   16'h0,    0, 0, 0,   2, 16'h0,    0, 0, 3, "late3"));
    tbl.push_back(v(1, 0, 0,   16'h0,    1, 0, 0,   2, 16'h0,    0, 0, 3, "ontime_same_cycle"));
    tbl.push_back(v(0, 0, 0,   16'h0,    1, 0, 0,   0, 16'h0,    0, 0, 0, "done4"));
    tbl.push_back(v(1, 0, 0,   16'h0,    0, 0, 0,   2, 16'h0,    0, 0, 3, "ontime_seen"));
    tbl.push_back(v(1, 0, 0,   16'h0,    0, 0, 0,   2, 16'h0,    0, 0, 4, "late4"));

    foreach (tbl[i]) apply(tbl[i]);
    quiet();

    // saturation: 260 more late swaps from 4 must stop at 255
    for (int k = 0; k < 260; k++)
      apply(v(1, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0, 0, "sat"));
    quiet();
    step();
    chk("late_saturate", 32'(late_count), 32'd255);

    // reset mid-line with data in both banks and a non-zero pixel on the output
    apply(v(0, 1, 200, 16'h1234, 0, 0, 0, 0, 16'h0, 0, 0, 0, "mr_draw200"));
    apply(v(0, 1, 201, 16'h4321, 0, 0, 0, 0, 16'h0, 0, 0, 0, "mr_draw201"));
    apply(v(1, 0, 0,   16'h0,    1, 0, 0, 0, 16'h0, 0, 0, 0, "mr_swap"));
    apply(v(0, 0, 0,   16'h0,    0, 1, 201, 1, 16'h4321, 1, 1, 255, "mr_rd201"));
    apply(v(0, 1, 300, 16'h5678, 0, 0, 0, 0, 16'h0, 0, 0, 0, "mr_draw300"));
    quiet();
    reset = 1;
    step();
    check_reset_outputs("midreset");
    reset = 0;
    wait_ready("reclear", 0);
    read_all_zero("post_clear_a");
    apply(v(1, 0, 0, 16'h0, 0, 0, 0, 2, 16'h0, 0, 0, 1, "post_swap_late"));
    quiet();
    read_all_zero("post_clear_b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
